// File: rtl/shunt_fringe_if.sv
// shunt_fringe_if: put, get, tx-link and rx-link signals of one shunt_fringe
// endpoint. The slave modport is the endpoint itself. The master modport is
// the local logic together with the link peer that drives the endpoint.
interface shunt_fringe_if #(
    parameter int N_SIG  = 4,
    parameter int DATA_W = 64
);
    localparam int IW = (N_SIG > 1) ? $clog2(N_SIG) : 1;

    // put side
    logic              put_req_i;
    logic [IW-1:0]     put_idx_i;
    logic [DATA_W-1:0] put_data_i;
    logic              put_busy_o;

    // outbound link
    logic              tx_valid_o;
    logic              tx_eos_o;
    logic [IW-1:0]     tx_idx_o;
    logic [DATA_W-1:0] tx_data_o;
    logic              tx_ready_i;

    // inbound link
    logic              rx_valid_i;
    logic              rx_eos_i;
    logic [IW-1:0]     rx_idx_i;
    logic [DATA_W-1:0] rx_data_i;
    logic              rx_ready_o;

    // get side
    logic              get_req_i;
    logic [IW-1:0]     get_idx_i;
    logic              get_ok_o;
    logic [DATA_W-1:0] get_data_o;

    modport slave (
        input  put_req_i, put_idx_i, put_data_i,
        output put_busy_o,
        output tx_valid_o, tx_eos_o, tx_idx_o, tx_data_o,
        input  tx_ready_i,
        input  rx_valid_i, rx_eos_i, rx_idx_i, rx_data_i,
        output rx_ready_o,
        input  get_req_i, get_idx_i,
        output get_ok_o, get_data_o
    );

    modport master (
        output put_req_i, put_idx_i, put_data_i,
        input  put_busy_o,
        input  tx_valid_o, tx_eos_o, tx_idx_o, tx_data_o,
        output tx_ready_i,
        output rx_valid_i, rx_eos_i, rx_idx_i, rx_data_i,
        input  rx_ready_o,
        output get_req_i, get_idx_i,
        input  get_ok_o, get_data_o
    );
endinterface

// File: rtl/shunt_fringe.sv
// shunt_fringe: data-exchange endpoint between two simulation partitions.
// Holds a payload/valid database per signal and forwards local puts over the
// outbound link. Inbound frames fill the database and local gets consume it.
// It also provides a saturating cycle time base, an end-of-simulation
// handshake and a freeze request that is raised while a get is waiting on data.
// Optional get watchdog: define SHUNT_FRINGE_WDOG_EN to build it in.
//
// state   | meaning
// --------+----------------------------------------------------------
// INIT    | waiting for the init_i pulse; link and database idle
// ACTIVE  | puts, gets and inbound frames are serviced
// EOS     | terminal; only the pending tx frame or EOS frame drains
module shunt_fringe #(
    parameter int N_SIG    = 4,
    parameter int DATA_W   = 64,
    parameter int TIME_W   = 32,
    parameter int WDOG_MAX = 10000
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               init_i,
    input  logic               eos_req_i,
    shunt_fringe_if.slave      bus,
    output logic               freeze_o,
    output logic               wdog_err_o,
    output logic               overrun_o,
    output logic [1:0]         state_o,
    output logic [TIME_W-1:0]  time_o
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_EOS    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] payload_q [N_SIG];
    logic [N_SIG-1:0]  valid_q;

    logic              tx_valid_q;
    logic              tx_eos_q;
    logic [$bits(bus.tx_idx_o)-1:0] tx_idx_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              eos_pend_q;

    logic              get_ok_q;
    logic [DATA_W-1:0] get_data_q;
    logic              freeze_q;
    logic              overrun_q;
    logic [TIME_W-1:0] time_q;

    logic is_active;
    logic rx_acc;
    logic rx_wr;
    logic get_hit;
    logic get_miss;
    logic put_fire;
    logic eos_fire;

    assign is_active = (state_q == ST_ACTIVE);
    assign rx_acc    = bus.rx_valid_i && is_active;
    assign rx_wr     = rx_acc && !bus.rx_eos_i;
    assign get_hit   = is_active && bus.get_req_i && valid_q[bus.get_idx_i];
    assign get_miss  = is_active && bus.get_req_i && !valid_q[bus.get_idx_i];
    // A put that arrives together with the local EOS request wins the buffer;
    // the EOS frame follows once that put drains.
    assign put_fire  = is_active && bus.put_req_i && !tx_valid_q;
    assign eos_fire  = (eos_pend_q || (is_active && eos_req_i)) && !tx_valid_q && !put_fire;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; EOS is only left through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   if (init_i) state_d = ST_ACTIVE;
            ST_ACTIVE: if (eos_req_i || (rx_acc && bus.rx_eos_i)) state_d = ST_EOS;
            ST_EOS:    state_d = ST_EOS;
            default:   state_d = ST_INIT;
        endcase
    end

    // State-derived outputs; a get in flight when EOS is entered never freezes.
    always_comb begin
        bus.rx_ready_o = is_active;
        state_o        = state_q;
        freeze_o       = freeze_q && (state_q != ST_EOS);
    end

    // Saturating cycle counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            time_q <= '0;
        end else if (time_q != '1) begin
            time_q <= time_q + 1'b1;
        end
    end

    // Tx buffer: loaded by a put or the EOS frame, held until accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_valid_q <= 1'b0;
            tx_eos_q   <= 1'b0;
            tx_idx_q   <= '0;
            tx_data_q  <= '0;
            eos_pend_q <= 1'b0;
        end else begin
            if (tx_valid_q && bus.tx_ready_i) begin
                tx_valid_q <= 1'b0;
            end
            if (put_fire) begin
                tx_valid_q <= 1'b1;
                tx_eos_q   <= 1'b0;
                tx_idx_q   <= bus.put_idx_i;
                tx_data_q  <= bus.put_data_i;
            end else if (eos_fire) begin
                tx_valid_q <= 1'b1;
                tx_eos_q   <= 1'b1;
                tx_idx_q   <= '0;
                tx_data_q  <= '0;
            end
            if (eos_fire) begin
                eos_pend_q <= 1'b0;
            end else if (is_active && eos_req_i) begin
                eos_pend_q <= 1'b1;
            end
        end
    end

    // Database: a same-cycle receive on the entry being got keeps it valid
    // with the new data because the receive write is ordered last.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_SIG; i++) begin
                payload_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            if (get_hit) begin
                valid_q[bus.get_idx_i] <= 1'b0;
            end
            if (rx_wr) begin
                payload_q[bus.rx_idx_i] <= bus.rx_data_i;
                valid_q[bus.rx_idx_i]   <= 1'b1;
            end
        end
    end

    // Get response, freeze request and sticky overrun flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            get_ok_q   <= 1'b0;
            get_data_q <= '0;
            freeze_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            get_ok_q   <= get_hit;
            get_data_q <= get_hit ? payload_q[bus.get_idx_i] : '0;
            freeze_q   <= get_miss;
            if (rx_wr && valid_q[bus.rx_idx_i] &&
                !(get_hit && (bus.get_idx_i == bus.rx_idx_i))) begin
                overrun_q <= 1'b1;
            end
        end
    end

`ifdef SHUNT_FRINGE_WDOG_EN
    localparam int WDW = $clog2(WDOG_MAX + 2);
    localparam logic [WDW-1:0] WDOG_LIM = WDW'(WDOG_MAX);
    localparam logic [WDW-1:0] WDOG_SAT = WDW'(WDOG_MAX + 1);

    logic [WDW-1:0] wdog_q;
    logic           wdog_err_q;

    // Get-wait watchdog; counts unsatisfied get cycles, saturating just past the limit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_q     <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            if (!bus.get_req_i || get_ok_q) begin
                wdog_q <= '0;
            end else if (get_miss && (wdog_q != WDOG_SAT)) begin
                wdog_q <= wdog_q + 1'b1;
            end
            if (wdog_q > WDOG_LIM) begin
                wdog_err_q <= 1'b1;
            end
        end
    end

    assign wdog_err_o = wdog_err_q;
`else
    // Watchdog not built: the error output is constant low.
    assign wdog_err_o = (WDOG_MAX < 0);
`endif

    assign bus.put_busy_o = tx_valid_q;
    assign bus.tx_valid_o = tx_valid_q;
    assign bus.tx_eos_o   = tx_eos_q;
    assign bus.tx_idx_o   = tx_idx_q;
    assign bus.tx_data_o  = tx_data_q;
    assign bus.get_ok_o   = get_ok_q;
    assign bus.get_data_o = get_data_q;
    assign overrun_o      = overrun_q;
    assign time_o         = time_q;

endmodule

// File: tb/tb_shunt_fringe.sv
// tb_shunt_fringe: directed, table-driven bench for shunt_fringe with
// scoreboards for returned get data and outbound frames.
module tb_shunt_fringe;
    localparam int N_SIG    = 4;
    localparam int DATA_W   = 64;
    localparam int TIME_W   = 32;
    localparam int WDOG_MAX = 10;
`ifdef SHUNT_FRINGE_WDOG_EN
    localparam bit WDOG_BUILT = 1'b1;
`else
    localparam bit WDOG_BUILT = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              init_i = 1'b0;
    logic              eos_req_i = 1'b0;
    logic              freeze_o;
    logic              wdog_err_o;
    logic              overrun_o;
    logic [1:0]        state_o;
    logic [TIME_W-1:0] time_o;

    shunt_fringe_if #(.N_SIG(N_SIG), .DATA_W(DATA_W)) bus ();

    shunt_fringe #(
        .N_SIG(N_SIG), .DATA_W(DATA_W), .TIME_W(TIME_W), .WDOG_MAX(WDOG_MAX)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .init_i(init_i), .eos_req_i(eos_req_i),
        .bus(bus), .freeze_o(freeze_o), .wdog_err_o(wdog_err_o),
        .overrun_o(overrun_o), .state_o(state_o), .time_o(time_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        eos;
        logic [1:0]  idx;
        logic [63:0] data;
    } frame_t;

    typedef struct {
        logic        rx_v;
        logic [1:0]  rx_idx;
        logic [63:0] rx_data;
        logic        get_v;
        logic [1:0]  get_idx;
        logic        exp_ok;
        logic        exp_frz;
        logic        exp_ovr;
        logic [63:0] exp_data;
    } vec_t;

    frame_t      tx_q[$];
    logic [63:0] get_q[$];
    vec_t        vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rv, input logic [1:0] ri, input logic [63:0] rd,
                                input logic gv, input logic [1:0] gi, input logic ok,
                                input logic frz, input logic ovr, input logic [63:0] d);
        vec_t v;
        v.rx_v = rv; v.rx_idx = ri; v.rx_data = rd;
        v.get_v = gv; v.get_idx = gi;
        v.exp_ok = ok; v.exp_frz = frz; v.exp_ovr = ovr; v.exp_data = d;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard monitors, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (rst_ni && bus.get_ok_o) begin
            if (get_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL get_ok unexpected: got data 0x%0h expected no pulse", bus.get_data_o);
            end else begin
                logic [63:0] e;
                e = get_q.pop_front();
                chk("get_data", bus.get_data_o, e);
            end
        end
        if (rst_ni && bus.tx_valid_o && bus.tx_ready_i) begin
            if (tx_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL tx frame unexpected: got eos %0b idx %0d data 0x%0h expected none",
                         bus.tx_eos_o, bus.tx_idx_o, bus.tx_data_o);
            end else begin
                frame_t f;
                f = tx_q.pop_front();
                chk("tx_eos", {63'd0, bus.tx_eos_o}, {63'd0, f.eos});
                if (!f.eos) begin
                    chk("tx_idx", {62'd0, bus.tx_idx_o}, {62'd0, f.idx});
                    chk("tx_data", bus.tx_data_o, f.data);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish before 50000");
        $fatal(1, "timeout");
    end

    initial begin
        int valid_cycles;

        vecs[0]  = mk(1, 2, 64'h55, 0, 0, 0, 0, 0, 64'h0);
        vecs[1]  = mk(0, 0, 64'h0,  1, 2, 1, 0, 0, 64'h55);
        vecs[2]  = mk(0, 0, 64'h0,  1, 2, 0, 1, 0, 64'h0);
        vecs[3]  = mk(0, 0, 64'h0,  0, 0, 0, 0, 0, 64'h0);
        vecs[4]  = mk(1, 1, 64'hAA, 0, 0, 0, 0, 0, 64'h0);
        vecs[5]  = mk(1, 1, 64'hBB, 1, 1, 1, 0, 0, 64'hAA);
        vecs[6]  = mk(0, 0, 64'h0,  1, 1, 1, 0, 0, 64'hBB);
        vecs[7]  = mk(1, 3, 64'h77, 1, 3, 0, 1, 0, 64'h0);
        vecs[8]  = mk(0, 0, 64'h0,  1, 3, 1, 0, 0, 64'h77);
        vecs[9]  = mk(1, 0, 64'h11, 0, 0, 0, 0, 0, 64'h0);
        vecs[10] = mk(1, 0, 64'h22, 0, 0, 0, 0, 1, 64'h0);
        vecs[11] = mk(0, 0, 64'h0,  1, 0, 1, 0, 1, 64'h22);
        vecs[12] = mk(0, 0, 64'h0,  1, 0, 0, 1, 1, 64'h0);
        vecs[13] = mk(0, 0, 64'h0,  0, 0, 0, 0, 1, 64'h0);

        bus.put_req_i = 0; bus.put_idx_i = 0; bus.put_data_i = 0;
        bus.tx_ready_i = 0;
        bus.rx_valid_i = 0; bus.rx_eos_i = 0; bus.rx_idx_i = 0; bus.rx_data_i = 0;
        bus.get_req_i = 0; bus.get_idx_i = 0;

        // reset values
        repeat (2) cyc();
        chk("rst state", {62'd0, state_o}, 64'd0);
        chk("rst time", {32'd0, time_o}, 64'd0);
        chk("rst tx_valid", {63'd0, bus.tx_valid_o}, 64'd0);
        chk("rst put_busy", {63'd0, bus.put_busy_o}, 64'd0);
        chk("rst rx_ready", {63'd0, bus.rx_ready_o}, 64'd0);
        chk("rst get_ok", {63'd0, bus.get_ok_o}, 64'd0);
        chk("rst get_data", bus.get_data_o, 64'd0);
        chk("rst freeze", {63'd0, freeze_o}, 64'd0);
        chk("rst wdog_err", {63'd0, wdog_err_o}, 64'd0);
        chk("rst overrun", {63'd0, overrun_o}, 64'd0);

        // release and init pulse
        rst_ni = 1;
        init_i = 1;
        cyc();
        init_i = 0;
        chk("init state", {62'd0, state_o}, 64'd1);
        chk("init rx_ready", {63'd0, bus.rx_ready_o}, 64'd1);
        repeat (4) cyc();
        chk("time after 5", {32'd0, time_o}, 64'd5);

        // table of receive/get vectors
        for (int i = 0; i < 14; i++) begin
            bus.rx_valid_i = vecs[i].rx_v;
            bus.rx_idx_i   = vecs[i].rx_idx;
            bus.rx_data_i  = vecs[i].rx_data;
            bus.get_req_i  = vecs[i].get_v;
            bus.get_idx_i  = vecs[i].get_idx;
            if (vecs[i].exp_ok) get_q.push_back(vecs[i].exp_data);
            cyc();
            chk($sformatf("v%0d get_ok", i), {63'd0, bus.get_ok_o}, {63'd0, vecs[i].exp_ok});
            chk($sformatf("v%0d freeze", i), {63'd0, freeze_o}, {63'd0, vecs[i].exp_frz});
            chk($sformatf("v%0d overrun", i), {63'd0, overrun_o}, {63'd0, vecs[i].exp_ovr});
        end
        bus.rx_valid_i = 0;
        bus.get_req_i  = 0;

        // put with back-pressure; a second put while busy is dropped
        bus.put_req_i = 1; bus.put_idx_i = 1; bus.put_data_i = 64'h1AB;
        bus.tx_ready_i = 0;
        tx_q.push_back('{eos: 1'b0, idx: 2'd1, data: 64'h1AB});
        cyc();
        bus.put_idx_i = 2; bus.put_data_i = 64'h2CD;
        chk("put busy", {63'd0, bus.put_busy_o}, 64'd1);
        valid_cycles = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.tx_valid_o) begin
                valid_cycles++;
                chk($sformatf("hold idx c%0d", c), {62'd0, bus.tx_idx_o}, 64'd1);
                chk($sformatf("hold data c%0d", c), bus.tx_data_o, 64'h1AB);
            end
            bus.tx_ready_i = (c >= 3);
            if (c >= 1) bus.put_req_i = 0;
            cyc();
        end
        chk("tx valid cycles", valid_cycles, 4);
        chk("tx idle after put", {63'd0, bus.tx_valid_o}, 64'd0);

        // watchdog on a get that never gets data
        bus.get_req_i = 1; bus.get_idx_i = 3;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk($sformatf("wdog freeze k%0d", k), {63'd0, freeze_o}, 64'd1);
            chk($sformatf("wdog err k%0d", k), {63'd0, wdog_err_o},
                {63'd0, WDOG_BUILT && (k >= 12)});
        end
        bus.get_req_i = 0;
        cyc();
        chk("wdog freeze drop", {63'd0, freeze_o}, 64'd0);
        chk("wdog err sticky", {63'd0, wdog_err_o}, {63'd0, WDOG_BUILT});

        // reset in the middle of a pending frame
        bus.tx_ready_i = 0;
        bus.put_req_i = 1; bus.put_idx_i = 2; bus.put_data_i = 64'h3EF;
        cyc();
        bus.put_req_i = 0;
        chk("mid put valid", {63'd0, bus.tx_valid_o}, 64'd1);
        #2 rst_ni = 0;
        #1;
        chk("mid rst tx_valid", {63'd0, bus.tx_valid_o}, 64'd0);
        chk("mid rst state", {62'd0, state_o}, 64'd0);
        chk("mid rst overrun", {63'd0, overrun_o}, 64'd0);
        chk("mid rst wdog", {63'd0, wdog_err_o}, 64'd0);
        chk("mid rst time", {32'd0, time_o}, 64'd0);
        cyc();
        rst_ni = 1;
        init_i = 1;
        bus.tx_ready_i = 1;
        cyc();
        init_i = 0;
        chk("reinit state", {62'd0, state_o}, 64'd1);
        chk("reinit tx discarded", {63'd0, bus.tx_valid_o}, 64'd0);

        // end of simulation
        eos_req_i = 1;
        tx_q.push_back('{eos: 1'b1, idx: 2'd0, data: 64'h0});
        cyc();
        eos_req_i = 0;
        chk("eos state", {62'd0, state_o}, 64'd2);
        chk("eos tx_valid", {63'd0, bus.tx_valid_o}, 64'd1);
        chk("eos tx_eos", {63'd0, bus.tx_eos_o}, 64'd1);
        chk("eos rx_ready", {63'd0, bus.rx_ready_o}, 64'd0);
        cyc();
        chk("eos frame gone", {63'd0, bus.tx_valid_o}, 64'd0);
        bus.put_req_i = 1; bus.put_idx_i = 1; bus.put_data_i = 64'h99;
        bus.get_req_i = 1; bus.get_idx_i = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("eos no put k%0d", k), {63'd0, bus.tx_valid_o}, 64'd0);
            chk($sformatf("eos no freeze k%0d", k), {63'd0, freeze_o}, 64'd0);
            chk($sformatf("eos state k%0d", k), {62'd0, state_o}, 64'd2);
        end
        bus.put_req_i = 0;
        bus.get_req_i = 0;
        cyc();
        chk("tx_q drained", tx_q.size(), 0);
        chk("get_q drained", get_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
